// File: rtl/seq_detect_pkg.sv
// Shared types, defaults and helpers for the serial pattern-detection controller.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned MAX_LEN_DEF = 8;
    localparam int unsigned LEN_W_DEF   = 4;
    localparam int unsigned CNT_W_DEF   = 8;

    localparam logic [7:0]  RST_PATTERN = 8'b0000_1101;
    localparam int unsigned RST_LEN     = 4;
    localparam logic        RST_OVERLAP = 1'b1;

    // Low `len` bits set; callers narrow the result to their pattern width.
    function automatic logic [31:0] len_mask(input logic [31:0] len);
        if (len >= 32'd32)
            len_mask = '1;
        else
            len_mask = (32'd1 << len) - 32'd1;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration, control and serial-stream bundle between the host side and the detector.
interface seq_detect_ctrl_if
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);

    logic               cfg_we;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_stop_cnt;
    logic               start;
    logic               stop;
    logic               x;
    logic               x_valid;
    logic               z;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   match_cnt;
    logic               irq;
    logic               irq_ack;

    modport master (
        output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_stop_cnt,
        output start, stop, x, x_valid, irq_ack,
        input  z, busy, done, match_cnt, irq
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_stop_cnt,
        input  start, stop, x, x_valid, irq_ack,
        output z, busy, done, match_cnt, irq
    );

endinterface

// File: rtl/seq_shift_match.sv
// Bit-serial history register, fill counter and length-masked pattern compare.
module seq_shift_match
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               shift_en,
    input  logic               clr,
    input  logic               x,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    output logic               hit
);

    logic [MAX_LEN-1:0] hist_q;
    logic [MAX_LEN-1:0] hist_next;
    logic [MAX_LEN-1:0] mask;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_next;

    always_comb begin
        hist_next = {hist_q[MAX_LEN-2:0], x};
        fill_next = (fill_q >= len) ? len : fill_q + 1'b1;
        mask      = MAX_LEN'(len_mask(32'(len)));
        hit       = shift_en && (fill_next >= len) &&
                    ((hist_next & mask) == (pattern & mask));
    end

    // clr also wipes history: once fill restarts at 0, no match can be
    // declared until len fresh bits have overwritten the compared window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (clr) begin
            hist_q <= '0;
            fill_q <= '0;
        end else if (shift_en) begin
            hist_q <= hist_next;
            fill_q <= fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run sequencing, configuration registers, match counting and auto-stop interrupt.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF,
    parameter int unsigned LEN_W   = LEN_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    seq_detect_ctrl_if.slave bus
);

    state_t             state_q;
    state_t             state_d;
    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               overlap_q;
    logic [CNT_W-1:0]   stop_cnt_q;
    logic [CNT_W-1:0]   match_cnt_q;
    logic [CNT_W-1:0]   cnt_inc;
    logic               z_q;
    logic               irq_q;
    logic               hit;
    logic               shift_en;
    logic               clr;
    logic               start_go;
    logic               cfg_ok;
    logic               auto_stop;
    logic               done_entry;

    assign shift_en = (state_q == RUN) && bus.x_valid;
    assign clr      = start_go || (hit && !overlap_q);

    seq_shift_match #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_match (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .clr      (clr),
        .x        (bus.x),
        .pattern  (pattern_q),
        .len      (len_q),
        .hit      (hit)
    );

    always_comb begin
        state_d    = state_q;
        start_go   = 1'b0;
        auto_stop  = 1'b0;
        done_entry = 1'b0;
        cnt_inc    = (match_cnt_q == '1) ? match_cnt_q : match_cnt_q + 1'b1;
        cfg_ok     = bus.cfg_we && (state_q != RUN) && (bus.cfg_len != '0) &&
                     (bus.cfg_len <= LEN_W'(MAX_LEN));
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    start_go = 1'b1;
                end
            end
            RUN: begin
                auto_stop = hit && (stop_cnt_q != '0) && (cnt_inc == stop_cnt_q);
                if (bus.stop) begin
                    state_d = IDLE;
                end else if (auto_stop) begin
                    state_d    = DONE;
                    done_entry = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q  <= MAX_LEN'(RST_PATTERN);
            len_q      <= LEN_W'(RST_LEN);
            overlap_q  <= RST_OVERLAP;
            stop_cnt_q <= '0;
        end else if (cfg_ok) begin
            pattern_q  <= bus.cfg_pattern;
            len_q      <= bus.cfg_len;
            overlap_q  <= bus.cfg_overlap;
            stop_cnt_q <= bus.cfg_stop_cnt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt_q <= '0;
            z_q         <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            z_q <= hit;
            if (start_go)
                match_cnt_q <= '0;
            else if (hit)
                match_cnt_q <= cnt_inc;
            if (done_entry)
                irq_q <= 1'b1;
            else if (bus.irq_ack)
                irq_q <= 1'b0;
        end
    end

    assign bus.z         = z_q;
    assign bus.busy      = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.match_cnt = match_cnt_q;
    assign bus.irq       = irq_q;

    busy_done_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(bus.busy && bus.done));

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed and randomized checks of seq_detect_ctrl against a bit-list reference model.
module tb_seq_detect_ctrl;
    import seq_detect_pkg::*;

    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_detect_ctrl_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int z_total = 0;

    // Reference model: the received bits as a list, and the number of bits
    // taken since the run started or since the last non-overlapping match.
    state_t     m_state;
    logic [7:0] m_pat;
    int         m_len;
    bit         m_ovl;
    int         m_stop;
    int         m_cnt;
    bit         m_irq;
    bit         m_z;
    int         m_fresh;
    logic       m_bits[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_pat   = 8'b0000_1101;
        m_len   = 4;
        m_ovl   = 1'b1;
        m_stop  = 0;
        m_cnt   = 0;
        m_irq   = 1'b0;
        m_z     = 1'b0;
        m_fresh = 0;
        m_bits.delete();
    endtask

    task automatic model_edge();
        bit     hit;
        bit     to_done;
        state_t st;
        hit     = 1'b0;
        to_done = 1'b0;
        st      = m_state;
        if (bus.cfg_we && st != RUN && int'(bus.cfg_len) >= 1 && int'(bus.cfg_len) <= MAX_LEN) begin
            m_pat  = bus.cfg_pattern;
            m_len  = int'(bus.cfg_len);
            m_ovl  = bus.cfg_overlap;
            m_stop = int'(bus.cfg_stop_cnt);
        end
        m_z = 1'b0;
        if (st == RUN) begin
            if (bus.x_valid) begin
                m_bits.push_back(bus.x);
                if (m_bits.size() > MAX_LEN)
                    void'(m_bits.pop_front());
                m_fresh++;
                if (m_fresh >= m_len) begin
                    hit = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (m_bits[m_bits.size() - m_len + k] != m_pat[m_len - 1 - k])
                            hit = 1'b0;
                end
                if (hit) begin
                    m_z = 1'b1;
                    if (m_cnt < CNT_MAX)
                        m_cnt++;
                    if (!m_ovl)
                        m_fresh = 0;
                end
            end
            if (bus.stop) begin
                m_state = IDLE;
            end else if (hit && m_stop != 0 && m_cnt == m_stop) begin
                m_state = DONE;
                to_done = 1'b1;
            end
        end else if (bus.start) begin
            m_state = RUN;
            m_cnt   = 0;
            m_fresh = 0;
            m_bits.delete();
        end
        if (to_done)
            m_irq = 1'b1;
        else if (bus.irq_ack)
            m_irq = 1'b0;
    endtask

    task automatic compare_all();
        if (bus.z === 1'b1)
            z_total++;
        check_val("z", 32'(bus.z), 32'(m_z));
        check_val("busy", 32'(bus.busy), 32'(m_state == RUN));
        check_val("done", 32'(bus.done), 32'(m_state == DONE));
        check_val("match_cnt", 32'(bus.match_cnt), 32'(m_cnt));
        check_val("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic clear_inputs();
        bus.cfg_we       = 1'b0;
        bus.cfg_pattern  = '0;
        bus.cfg_len      = '0;
        bus.cfg_overlap  = 1'b0;
        bus.cfg_stop_cnt = '0;
        bus.start        = 1'b0;
        bus.stop         = 1'b0;
        bus.x            = 1'b0;
        bus.x_valid      = 1'b0;
        bus.irq_ack      = 1'b0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic write_cfg(input logic [7:0] pat, input int len, input bit ovl, input int stopc);
        bus.cfg_we       = 1'b1;
        bus.cfg_pattern  = pat;
        bus.cfg_len      = LEN_W'(len);
        bus.cfg_overlap  = ovl;
        bus.cfg_stop_cnt = CNT_W'(stopc);
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic pulse(input bit is_start);
        if (is_start) bus.start = 1'b1;
        else          bus.stop  = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] bits, input int n);
        logic [31:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) begin
            bus.x       = v[i];
            bus.x_valid = 1'b1;
            tick();
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        int z0;
        clear_inputs();
        model_reset();
        #3;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // Default pattern 1101, overlapping.
        pulse(1'b1);
        z0 = z_total;
        send_bits(32'b1101101, 7);
        check_val("t1_zcount", 32'(z_total - z0), 32'd2);
        check_val("t1_cnt", 32'(bus.match_cnt), 32'd2);
        check_val("t1_busy", 32'(bus.busy), 32'd1);

        // Non-overlapping.
        pulse(1'b0);
        write_cfg(8'b0000_1101, 4, 1'b0, 0);
        pulse(1'b1);
        z0 = z_total;
        send_bits(32'b1101101, 7);
        check_val("t2_zcount", 32'(z_total - z0), 32'd1);
        check_val("t2_cnt", 32'(bus.match_cnt), 32'd1);

        // Auto-stop after two matches.
        pulse(1'b0);
        write_cfg(8'b0000_1101, 4, 1'b1, 2);
        pulse(1'b1);
        send_bits(32'b1101101, 7);
        check_val("t3_done", 32'(bus.done), 32'd1);
        check_val("t3_irq", 32'(bus.irq), 32'd1);
        check_val("t3_busy", 32'(bus.busy), 32'd0);
        z0 = z_total;
        send_bits(32'b1101, 4);
        check_val("t3_zcount", 32'(z_total - z0), 32'd0);
        check_val("t3_cnt", 32'(bus.match_cnt), 32'd2);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check_val("t3_irq_ack", 32'(bus.irq), 32'd0);
        check_val("t3_done_hold", 32'(bus.done), 32'd1);

        // Single-bit pattern with an invalid gap holding x high.
        write_cfg(8'b0000_0001, 1, 1'b1, 0);
        pulse(1'b1);
        z0 = z_total;
        send_bits(32'b1, 1);
        bus.x = 1'b1;
        bus.x_valid = 1'b0;
        tick();
        send_bits(32'b01, 2);
        tick();
        check_val("t4_zcount", 32'(z_total - z0), 32'd2);

        // Illegal length dropped, write during RUN ignored, counter saturation.
        pulse(1'b0);
        write_cfg(8'b0000_0000, 0, 1'b0, 1);
        pulse(1'b1);
        write_cfg(8'b0000_0000, 4, 1'b0, 1);
        z0 = z_total;
        bus.x = 1'b1;
        bus.x_valid = 1'b1;
        for (int i = 0; i < 300; i++)
            tick();
        bus.x_valid = 1'b0;
        tick();
        check_val("t5_zcount", 32'(z_total - z0), 32'd300);
        check_val("t5_cnt_sat", 32'(bus.match_cnt), 32'(CNT_MAX));

        // Reset mid-pattern restores defaults; restart needs all four bits.
        pulse(1'b0);
        write_cfg(8'b0000_0011, 2, 1'b0, 3);
        pulse(1'b1);
        send_bits(32'b11, 2);
        async_reset();
        check_val("t6_cnt", 32'(bus.match_cnt), 32'd0);
        pulse(1'b1);
        z0 = z_total;
        send_bits(32'b110, 3);
        check_val("t6_early_z", 32'(z_total - z0), 32'd0);
        send_bits(32'b1, 1);
        tick();
        check_val("t6_zcount", 32'(z_total - z0), 32'd1);

        // Randomized traffic with occasional illegal writes and resets.
        for (int i = 0; i < 4000; i++) begin
            clear_inputs();
            if ($urandom_range(0, 7) == 0) begin
                bus.cfg_we       = 1'b1;
                bus.cfg_pattern  = MAX_LEN'($urandom);
                bus.cfg_len      = ($urandom_range(0, 5) == 0) ? LEN_W'($urandom_range(0, 15))
                                                               : LEN_W'($urandom_range(1, 4));
                bus.cfg_overlap  = 1'($urandom);
                bus.cfg_stop_cnt = CNT_W'($urandom_range(0, 4));
            end
            bus.start   = ($urandom_range(0, 9) == 0);
            bus.stop    = ($urandom_range(0, 39) == 0);
            bus.x       = 1'($urandom);
            bus.x_valid = ($urandom_range(0, 3) != 0);
            bus.irq_ack = ($urandom_range(0, 7) == 0);
            tick();
            if ($urandom_range(0, 499) == 0)
                async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
